fm_audio_out_sched: RTL and testbench
=====================================

Name: fm_audio_out_sched

Overview:
- Paced stereo output scheduler at the back end of fm_radio_top.
- Drains the left and right audio FIFOs (first-word-fall-through) in lockstep, one stereo frame per audio-rate tick.
- Serialises each frame as L then R on a single valid/ready output stream toward the DAC/serialiser.
- Counts underruns (data not ready at a tick) and slips (ticks lost while the output stalls).

Parameters:
- DATA_SIZE, 32: audio sample width, bits.
- RATE_DIV, 32: clock cycles per stereo frame. Legal range is 4..65535.
- CNT_W, 16: width of the underrun and slip counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run control; high permits ticks and FIFO fetches.
- left_empty  in  1  left audio FIFO empty.
- left_dout  in  DATA_SIZE  left FIFO head word, valid when !left_empty.
- left_rd_en  out  1  pop left FIFO.
- right_empty  in  1  right audio FIFO empty.
- right_dout  in  DATA_SIZE  right FIFO head word, valid when !right_empty.
- right_rd_en  out  1  pop right FIFO.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_SIZE  output sample (signed).
- out_chan  out  1  0 = left, 1 = right.
- underrun_count  out  CNT_W  saturating count of ticks with a FIFO empty.
- slip_count  out  CNT_W  saturating count of ticks discarded during a stall.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WAIT; tick counter=0; pending=0.
  - out_valid=0, out_data=0, out_chan=0; left_rd_en=right_rd_en=0.
  - Both counters=0.
  - Reset asserted mid-frame aborts the frame; the captured samples are lost.
- Tick counter:
  - enable=1: counts 0..RATE_DIV-1 and wraps.
  - tick = enable && counter==RATE_DIV-1 (combinational).
  - enable=0: counter held at 0 and pending cleared.
- FSM states: WAIT, FETCH, SEND_L, SEND_R.
- WAIT, on a start condition (tick or pending):
  - Both FIFOs non-empty: go to FETCH and clear pending.
  - Either FIFO empty: underrun_count += 1, no pop, stay in WAIT.
  - If pending was set and tick is also high, pending remains set.
- Tick in FETCH/SEND_L/SEND_R:
  - pending=0: set pending=1.
  - pending=1: slip_count += 1.
- FETCH (exactly 1 cycle):
  - left_rd_en=right_rd_en=1 combinationally.
  - left_dout and right_dout are captured at the closing edge.
  - Go to SEND_L.
  - The two rd_en are never asserted independently, and are asserted only in FETCH.
- SEND_L:
  - out_valid=1, out_chan=0, out_data=captured left.
  - On out_ready=1, go to SEND_R.
- SEND_R:
  - out_valid=1, out_chan=1, out_data=captured right.
  - On out_ready=1, go to WAIT.
- Output rules:
  - out_data and out_chan are held stable while out_valid && !out_ready.
  - out_valid=0 in WAIT and FETCH.
- Latency:
  - Tick in cycle T, with WAIT and both non-empty: rd_en in T+1, L valid in T+2.
  - With ready=1: R valid in T+3, WAIT in T+4.
  - Minimum 4 cycles per frame, hence RATE_DIV≥4.
- enable falling mid-frame: the frame completes normally and no new FETCH occurs.
- Both counters saturate at all-ones (2^CNT_W-1) and clear only on reset.
- Samples pass through unmodified; no arithmetic on data.

Test Plan:
- Continuous streaming:
  - Stimulus: RATE_DIV=8, FIFOs preloaded L={0x00000400, 0x00000800}, R={0xFFFFFC00, 0x00000C00}, ready=1.
  - Required: rd_en pulses 1 cycle at T+1 and T+9; output sequence 0x400/L, 0xFFFFFC00/R, 0x800/L, 0xC00/R; words spaced exactly 8 cycles per frame.
- Underrun:
  - Stimulus: right FIFO empty, left non-empty, two ticks.
  - Required: no rd_en on either FIFO; underrun_count=1 then 2; out_valid stays 0.
- Stall:
  - Stimulus: RATE_DIV=8, tick at T, out_ready=0 during T+2..T+17.
  - Required: L word stable through the stall; tick at T+8 sets pending; tick at T+16 gives slip_count=1; WAIT at T+20 triggers FETCH at T+21, next L valid at T+22.
- Enable drop:
  - Stimulus: enable=0 during SEND_R.
  - Required: R still delivered on ready; no further rd_en; counter reads 0; counters unchanged.
- Reset mid-frame:
  - Stimulus: reset=0 during SEND_L.
  - Required: out_valid=0 immediately (no clock edge); counters=0; after release, first tick at cycle RATE_DIV-1 after enable.
- Saturation:
  - Stimulus: CNT_W=4, RATE_DIV=4, FIFOs empty, 20 ticks.
  - Required: underrun_count stops at 0xF.

Source files
------------

// File: rtl/fm_audio_out_sched.sv
// fm_audio_out_sched: paced stereo output scheduler.
// Drains the left/right FWFT audio FIFOs in lockstep, one frame per audio-rate
// tick, and serialises each frame as L then R on one valid/ready stream.
// Counts underruns (a FIFO empty at a start) and slips (ticks lost in a stall).
module fm_audio_out_sched #(
  parameter int DATA_SIZE = 32,
  parameter int RATE_DIV  = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 left_empty,
  input  logic [DATA_SIZE-1:0] left_dout,
  output logic                 left_rd_en,
  input  logic                 right_empty,
  input  logic [DATA_SIZE-1:0] right_dout,
  output logic                 right_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_chan,
  output logic [CNT_W-1:0]     underrun_count,
  output logic [CNT_W-1:0]     slip_count
);

  localparam int                TW        = $clog2(RATE_DIV);
  localparam logic [TW-1:0]     TICK_LAST = TW'(RATE_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    WAIT,
    FETCH,
    SEND_L,
    SEND_R
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic                   pending;
  logic [DATA_SIZE-1:0]   right_q;

  // Audio-rate divider: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = enable && (tick_cnt == TICK_LAST);

  // Both FIFOs pop together, and only in the single FETCH cycle.
  assign left_rd_en  = (state == FETCH);
  assign right_rd_en = (state == FETCH);

  // Frame sequencer with registered stream outputs, pending tick and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= WAIT;
      pending        <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_chan       <= 1'b0;
      right_q        <= '0;
      underrun_count <= '0;
      slip_count     <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (tick || pending) begin
            if (!left_empty && !right_empty) begin
              state <= FETCH;
            end else if (underrun_count != CNT_MAX) begin
              underrun_count <= underrun_count + 1'b1;
            end
            // A start consumes the pending request; a tick landing in the
            // same cycle becomes the next one.
            pending <= pending && tick;
          end
        end
        FETCH: begin
          out_valid <= 1'b1;
          out_chan  <= 1'b0;
          out_data  <= left_dout;
          right_q   <= right_dout;
          state     <= SEND_L;
        end
        SEND_L: begin
          if (out_ready) begin
            out_chan <= 1'b1;
            out_data <= right_q;
            state    <= SEND_R;
          end
        end
        SEND_R: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase

      // Ticks arriving mid-frame: remember one, count any further as slips.
      if (tick && (state != WAIT)) begin
        if (!pending) begin
          pending <= 1'b1;
        end else if (slip_count != CNT_MAX) begin
          slip_count <= slip_count + 1'b1;
        end
      end

      // Disabling discards any remembered tick; the current frame still ends.
      if (!enable) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fm_audio_out_sched.sv
// Self-checking bench for fm_audio_out_sched (RATE_DIV=8, CNT_W=4).
// FIFOs are modelled as arrays; a scoreboard holds the expected L/R word order
// and directed phases check timing against the frame schedule arithmetic.
module tb_fm_audio_out_sched;

  localparam int DW = 32;
  localparam int RD = 8;
  localparam int CW = 4;

  typedef logic [DW:0] word_t;  // {chan, data}

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          left_empty, right_empty;
  logic [DW-1:0] left_dout, right_dout;
  logic          left_rd_en, right_rd_en;
  logic          out_valid, out_ready, out_chan;
  logic [DW-1:0] out_data;
  logic [CW-1:0] underrun_count, slip_count;

  int vectors = 0;
  int miscompares = 0;

  // FIFO models and scoreboard.
  logic [DW-1:0] lmem [64];
  logic [DW-1:0] rmem [64];
  int            lwr = 0, lrd = 0, rwr = 0, rrd = 0;
  word_t         exp_q [$];

  fm_audio_out_sched #(.DATA_SIZE(DW), .RATE_DIV(RD), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .left_empty(left_empty), .left_dout(left_dout), .left_rd_en(left_rd_en),
    .right_empty(right_empty), .right_dout(right_dout), .right_rd_en(right_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .underrun_count(underrun_count), .slip_count(slip_count)
  );

  always #5 clock = ~clock;

  assign left_empty  = (lwr == lrd);
  assign right_empty = (rwr == rrd);
  assign left_dout   = lmem[lrd[5:0]];
  assign right_dout  = rmem[rrd[5:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lmem[lwr[5:0]] = l; lwr++;
    rmem[rwr[5:0]] = r; rwr++;
  endtask

  // Popped FIFO words become the expected stream: L then R per frame.
  always @(posedge clock) begin
    if (left_rd_en) begin
      exp_q.push_back({1'b0, lmem[lrd[5:0]]});
      lrd <= lrd + 1;
    end
    if (right_rd_en) begin
      exp_q.push_back({1'b1, rmem[rrd[5:0]]});
      rrd <= rrd + 1;
    end
  end

  // Stream monitor: accepted words follow the scoreboard; stalled words hold.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_chan;
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_chan", out_chan, prev_chan);
      end
      if (out_valid && out_ready) begin
        logic [63:0] e;
        e = (exp_q.size() != 0) ? {31'b0, exp_q.pop_front()} : 64'hDEAD_0000_0000_0000;
        check("sb_word", {31'b0, out_chan, out_data}, e);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_chan  = out_chan;
    end
  end

  initial begin
    logic [DW-1:0] a1, a2, b1, b2, c1, c2, d1, d2, e1, f1;
    logic          ev;
    logic [DW-1:0] ed;
    a1 = $urandom(); a2 = $urandom(); b1 = $urandom(); b2 = $urandom();
    c1 = $urandom(); c2 = $urandom(); d1 = $urandom(); d2 = $urandom();
    e1 = $urandom(); f1 = $urandom();

    // Reset state.
    reset = 1'b0; enable = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);
    check("rst_rd_en", {left_rd_en, right_rd_en}, 0);
    check("rst_underrun", underrun_count, 0);
    check("rst_slip", slip_count, 0);
    @(posedge clock); #1 reset = 1'b1;

    // Continuous streaming: ticks at 7 and 15 -> pops at 8/16, words at 9,10,17,18.
    push_frame(32'h0000_0400, 32'hFFFF_FC00);
    push_frame(32'h0000_0800, 32'h0000_0C00);
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      @(negedge clock);
      check("stream_rd_en_l", left_rd_en, (c == 8 || c == 16));
      check("stream_rd_en_r", right_rd_en, (c == 8 || c == 16));
      check("stream_valid", out_valid, (c == 9 || c == 10 || c == 17 || c == 18));
    end
    @(posedge clock); #1 enable = 1'b0;
    check("stream_underrun", underrun_count, 0);

    // Underrun: right FIFO empty, ticks at 7 and 15.
    lmem[lwr[5:0]] = $urandom(); lwr++;
    for (int c = 0; c < 17; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      @(negedge clock);
      check("ur_rd_en", {left_rd_en, right_rd_en}, 0);
      check("ur_valid", out_valid, 0);
      check("ur_count", underrun_count, (c >= 8) + (c >= 16));
    end
    @(posedge clock); #1 enable = 1'b0;
    lwr = lrd;

    // Stall: tick T=7, ready low over cycles 9..24; pending at 15, slip at 23.
    push_frame(a1, b1);
    push_frame(a2, b2);
    for (int c = 0; c < 31; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      out_ready = !(c >= 9 && c <= 24);
      @(negedge clock);
      ev = (c >= 9 && c <= 26) || (c == 29 || c == 30);
      ed = (c <= 25) ? a1 : (c == 26) ? b1 : (c == 29) ? a2 : b2;
      check("stall_rd_en", left_rd_en, (c == 8 || c == 28));
      check("stall_valid", out_valid, ev);
      if (ev) begin
        check("stall_chan", out_chan, (c == 26 || c == 30));
        check("stall_data", out_data, ed);
      end
      check("stall_slip", slip_count, (c >= 24));
    end
    @(posedge clock); #1 enable = 1'b0;
    check("stall_underrun", underrun_count, 2);

    // Enable drop during SEND_R: R still delivered, no further pops.
    push_frame(c1, d1);
    push_frame(c2, d2);
    for (int c = 0; c < 26; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      if (c == 10) enable = 1'b0;
      out_ready = !(c == 10 || c == 11);
      @(negedge clock);
      ev = (c >= 9 && c <= 12);
      check("edrop_rd_en", right_rd_en, (c == 8));
      check("edrop_valid", out_valid, ev);
      if (ev) begin
        check("edrop_chan", out_chan, (c >= 10));
        check("edrop_data", out_data, (c == 9) ? c1 : d1);
      end
      if (c >= 11) check("edrop_divider", dut.tick_cnt, 0);
    end
    check("edrop_underrun", underrun_count, 2);
    check("edrop_slip", slip_count, 1);
    check("edrop_fifo_left", lwr - lrd, 1);

    // Reset asserted during SEND_L: outputs drop without a clock edge.
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin enable = 1'b1; out_ready = 1'b0; end
      @(negedge clock);
      check("rmid_valid", out_valid, (c >= 9));
      if (c >= 9) check("rmid_data", out_data, c2);
    end
    #2 reset = 1'b0;
    #1;
    check("rmid_async_valid", out_valid, 0);
    check("rmid_async_data", out_data, 0);
    check("rmid_async_underrun", underrun_count, 0);
    check("rmid_async_slip", slip_count, 0);
    @(posedge clock); #1 enable = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1 reset = 1'b1;
    exp_q.delete();

    // After release: first tick at RATE_DIV-1 cycles after enable.
    push_frame(e1, f1);
    for (int c = 0; c < 13; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      @(negedge clock);
      if (c <= 8) check("post_tick", dut.tick, (c == RD - 1));
      check("post_rd_en", left_rd_en, (c == RD));
      check("post_valid", out_valid, (c == RD + 1 || c == RD + 2));
    end
    @(posedge clock); #1 enable = 1'b0;

    // Saturation: FIFOs empty, 20 ticks, underrun_count sticks at 0xF.
    for (int c = 0; c <= 20 * RD; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      @(negedge clock);
      if (c % RD == 0) check("sat_underrun", underrun_count, (c / RD > 15) ? 15 : c / RD);
    end
    check("sat_slip", slip_count, 0);
    check("sat_valid", out_valid, 0);
    @(posedge clock); #1 enable = 1'b0;

    // Random back-pressure: scoreboard and hold checks run in the monitor.
    for (int i = 0; i < 6; i++) push_frame($urandom(), $urandom());
    for (int c = 0; c < 120; c++) begin
      @(posedge clock); #1;
      if (c == 0) enable = 1'b1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    enable = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("rand_drained", exp_q.size(), 0);
    check("rand_fifo_left", lwr - lrd, 0);
    check("rand_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
